// File: rtl/speles_pkg.sv
`default_nettype none
// ============================================================================
//  Package : speles_pkg
//  Purpose : Shared state encoding for the binary-number guessing game
//            controller and its helpers.
//  Rev     : 1.0  initial release
// ============================================================================
package speles_pkg;

   // Encoding is visible on the state output port; keep values fixed.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_CHECK = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

endpackage : speles_pkg
`default_nettype wire

// File: rtl/speles_timer.sv
`default_nettype none
// ============================================================================
//  Module  : speles_timer
//  Purpose : Per-round countdown. Clear beats load beats decrement; the
//            decrement happens on tick unless frozen and stops at zero.
//            expire flags the tick that takes the count from 1 to 0.
//  Rev     : 1.0  initial release
// ============================================================================
module speles_timer #(
   parameter int TIME_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   input  logic              tick,
   input  logic              freeze,
   output logic [TIME_W-1:0] value,
   output logic              expire
);

   logic [TIME_W-1:0] value_q;

   // Countdown register with clear/load/decrement priority.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= load_val;
      end else if (tick && !freeze && (value_q != '0)) begin
         value_q <= value_q - TIME_W'(1);
      end
   end

   assign value  = value_q;
   // Combinational so the controller can react in the same cycle.
   assign expire = tick && !freeze && (value_q == TIME_W'(1));

endmodule : speles_timer
`default_nettype wire

// File: rtl/speles_logika_v2.sv
`default_nettype none
// ============================================================================
//  Module  : speles_logika_v2
//  Purpose : Game controller for the binary guessing game: IDLE/PLAY/CHECK/
//            OVER sequencing, level counter, per-level countdown reload and
//            optional lives.
//  Config  : SPELES_LIVES_EN - when defined, wrong guesses and timeouts cost
//            a life instead of ending the game immediately.
//  Rev     : 1.0  initial release
// ============================================================================
module speles_logika_v2
   import speles_pkg::*;
#(
   parameter int LEVEL_W   = 8,
   parameter int MAX_LEVEL = 255,
   parameter int TIME_W    = 5,
   parameter int TIME_INIT = 20,
   parameter int TIME_STEP = 1,
   parameter int TIME_MIN  = 5,
   parameter int LIVES     = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               guess_b,
   input  logic               cmp_r,
   input  logic               end_f,
   input  logic               tick,
   output logic [1:0]         state,
   output logic [LEVEL_W-1:0] level,
   output logic               time_f,
   output logic [TIME_W-1:0]  time_v,
   output logic               g_enable,
   output logic               win,
   output logic [2:0]         lives
);

   // Reload arithmetic runs wide enough that (level-1)*TIME_STEP never wraps.
   localparam int RW = LEVEL_W + TIME_W;

   localparam logic [2:0] LIVES_CFG = 3'(LIVES);
`ifdef SPELES_LIVES_EN
   localparam logic [2:0] LIVES_INIT = LIVES_CFG;
`else
   // Lives feature compiled out: the counter is held at zero.
   localparam logic [2:0] LIVES_INIT = LIVES_CFG & 3'd0;
`endif

   state_t               state_q, state_d;
   logic                 guess_q;
   logic                 press;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic                 time_f_q, time_f_d;
   logic                 win_q, win_d;
   logic [2:0]           lives_q, lives_d;
   logic                 g_enable_q;
   logic                 wrong;
   logic [LEVEL_W-1:0]   reload_lvl;
   logic                 tmr_load, tmr_clear, tmr_freeze, tmr_expire;
   logic [TIME_W-1:0]    tmr_load_val, tmr_value;

   // Seconds granted for a round at level lvl, clamped at TIME_MIN.
   function automatic logic [TIME_W-1:0] reload_for(input logic [LEVEL_W-1:0] lvl);
      logic [RW-1:0] steps;
      logic [RW-1:0] init_e;
      logic [RW-1:0] min_e;
      steps  = (RW'(lvl) - RW'(1)) * RW'(TIME_STEP);
      init_e = RW'(TIME_INIT);
      min_e  = RW'(TIME_MIN);
      if (steps > (init_e - min_e)) begin
         return TIME_W'(TIME_MIN);
      end
      return TIME_W'(init_e - steps);
   endfunction

   assign press = guess_b && !guess_q;

   // Timer only counts in PLAY, and abort or press in the same cycle win over tick.
   assign tmr_freeze   = !((state_q == ST_PLAY) && !end_f && !press);
   assign tmr_load_val = reload_for(reload_lvl);

   speles_timer #(
      .TIME_W (TIME_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clear),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .tick     (tick),
      .freeze   (tmr_freeze),
      .value    (tmr_value),
      .expire   (tmr_expire)
   );

   // Next-state and next-register logic; abort beats press beats tick.
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      time_f_d   = time_f_q;
      win_d      = win_q;
      lives_d    = lives_q;
      tmr_load   = 1'b0;
      tmr_clear  = 1'b0;
      reload_lvl = level_q;
      wrong      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (press) begin
               state_d    = ST_PLAY;
               level_d    = LEVEL_W'(1);
               time_f_d   = 1'b0;
               win_d      = 1'b0;
               lives_d    = LIVES_INIT;
               reload_lvl = LEVEL_W'(1);
               tmr_load   = 1'b1;
            end
         end
         ST_PLAY: begin
            if (end_f) begin
               state_d = ST_OVER;
            end else if (press) begin
               state_d = ST_CHECK;
            end else if (tmr_expire) begin
               time_f_d = 1'b1;
               wrong    = 1'b1;
            end
         end
         ST_CHECK: begin
            if (end_f) begin
               state_d = ST_OVER;
            end else if (press) begin
               if (cmp_r) begin
                  if (level_q == LEVEL_W'(MAX_LEVEL)) begin
                     state_d = ST_OVER;
                     win_d   = 1'b1;
                  end else begin
                     state_d    = ST_PLAY;
                     level_d    = level_q + LEVEL_W'(1);
                     reload_lvl = level_q + LEVEL_W'(1);
                     tmr_load   = 1'b1;
                  end
               end else begin
                  wrong = 1'b1;
               end
            end
         end
         ST_OVER: begin
            if (press) begin
               state_d   = ST_IDLE;
               level_d   = '0;
               time_f_d  = 1'b0;
               win_d     = 1'b0;
               lives_d   = 3'd0;
               tmr_clear = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef SPELES_LIVES_EN
      if (wrong) begin
         if (lives_q <= 3'd1) begin
            lives_d = 3'd0;
            state_d = ST_OVER;
         end else begin
            lives_d    = lives_q - 3'd1;
            reload_lvl = level_q;
            tmr_load   = 1'b1;
            time_f_d   = 1'b0;
            state_d    = ST_PLAY;
         end
      end
`else
      if (wrong) begin
         state_d = ST_OVER;
      end
`endif
   end

   // State and game registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         guess_q    <= 1'b0;
         level_q    <= '0;
         time_f_q   <= 1'b0;
         win_q      <= 1'b0;
         lives_q    <= 3'd0;
         g_enable_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         guess_q    <= guess_b;
         level_q    <= level_d;
         time_f_q   <= time_f_d;
         win_q      <= win_d;
         lives_q    <= lives_d;
         g_enable_q <= (state_d == ST_PLAY);
      end
   end

   assign state    = state_q;
   assign level    = level_q;
   assign time_f   = time_f_q;
   assign time_v   = tmr_value;
   assign g_enable = g_enable_q;
   assign win      = win_q;
   assign lives    = lives_q;

endmodule : speles_logika_v2
`default_nettype wire

// File: tb/tb_speles_logika_v2.sv
`default_nettype none
// ============================================================================
//  Module  : tb_speles_logika_v2
//  Purpose : Bench for speles_logika_v2: directed game scenarios followed by
//            random button/tick/compare traffic, all against a reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_speles_logika_v2;

   localparam int LEVEL_W   = 8;
   localparam int MAX_LEVEL = 3;
   localparam int TIME_W    = 5;
   localparam int TIME_INIT = 20;
   localparam int TIME_STEP = 8;
   localparam int TIME_MIN  = 5;
   localparam int LIVES     = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               guess_b = 1'b0;
   logic               cmp_r = 1'b0;
   logic               end_f = 1'b0;
   logic               tick = 1'b0;
   logic [1:0]         state;
   logic [LEVEL_W-1:0] level;
   logic               time_f;
   logic [TIME_W-1:0]  time_v;
   logic               g_enable;
   logic               win;
   logic [2:0]         lives;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int m_state, m_level, m_time, m_tf, m_win, m_lives, m_gprev;

   speles_logika_v2 #(
      .LEVEL_W   (LEVEL_W),
      .MAX_LEVEL (MAX_LEVEL),
      .TIME_W    (TIME_W),
      .TIME_INIT (TIME_INIT),
      .TIME_STEP (TIME_STEP),
      .TIME_MIN  (TIME_MIN),
      .LIVES     (LIVES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .guess_b  (guess_b),
      .cmp_r    (cmp_r),
      .end_f    (end_f),
      .tick     (tick),
      .state    (state),
      .level    (level),
      .time_f   (time_f),
      .time_v   (time_v),
      .g_enable (g_enable),
      .win      (win),
      .lives    (lives)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int reload(input int lvl);
      int r;
      r = TIME_INIT - (lvl - 1) * TIME_STEP;
      return (r < TIME_MIN) ? TIME_MIN : r;
   endfunction

   task automatic m_clear();
      m_state = 0; m_level = 0; m_time = 0; m_tf = 0; m_win = 0; m_lives = 0;
   endtask

   task automatic m_wrong();
`ifdef SPELES_LIVES_EN
      m_lives = m_lives - 1;
      if (m_lives == 0) begin
         m_state = 3;
      end else begin
         m_time  = reload(m_level);
         m_tf    = 0;
         m_state = 1;
      end
`else
      m_state = 3;
`endif
   endtask

   task automatic m_step(input bit r, input bit g, input bit c, input bit e, input bit t);
      bit p;
      p = g && !m_gprev;
      m_gprev = r ? 0 : g;
      if (r) begin
         m_clear();
      end else begin
         case (m_state)
            0: if (p) begin
                  m_state = 1; m_level = 1; m_time = TIME_INIT; m_tf = 0; m_win = 0;
`ifdef SPELES_LIVES_EN
                  m_lives = LIVES;
`else
                  m_lives = 0;
`endif
               end
            1: if (e) m_state = 3;
               else if (p) m_state = 2;
               else if (t) begin
                  if (m_time > 1) m_time = m_time - 1;
                  else begin
                     m_time = 0; m_tf = 1; m_wrong();
                  end
               end
            2: if (e) m_state = 3;
               else if (p) begin
                  if (c) begin
                     if (m_level == MAX_LEVEL) begin
                        m_state = 3; m_win = 1;
                     end else begin
                        m_level = m_level + 1; m_time = reload(m_level); m_state = 1;
                     end
                  end else begin
                     m_wrong();
                  end
               end
            default: if (p) m_clear();
         endcase
      end
   endtask

   task automatic check_all();
      chk("state",    int'(state),    m_state);
      chk("level",    int'(level),    m_level);
      chk("time_v",   int'(time_v),   m_time);
      chk("time_f",   int'(time_f),   m_tf);
      chk("g_enable", int'(g_enable), (m_state == 1) ? 1 : 0);
      chk("win",      int'(win),      m_win);
      chk("lives",    int'(lives),    m_lives);
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge.
   task automatic apply(input bit r, input bit g, input bit c, input bit e, input bit t);
      rst = r; guess_b = g; cmp_r = c; end_f = e; tick = t;
      m_step(r, g, c, e, t);
      @(negedge clk);
      check_all();
   endtask

   // Full button press: rising edge then release.
   task automatic push(input bit c);
      apply(0, 1, c, 0, 0);
      apply(0, 0, 0, 0, 0);
   endtask

   initial begin
      m_gprev = 0;
      m_clear();

      // Reset state
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0);

      // Start, count down three ticks, then press+tick together
      push(0);
      repeat (3) apply(0, 0, 0, 0, 1);
      chk("time_after_3_ticks", int'(time_v), TIME_INIT - 3);
      apply(0, 1, 0, 0, 1);
      chk("press_beats_tick", int'(time_v), TIME_INIT - 3);
      apply(0, 0, 0, 0, 0);

      // Correct guesses: level 2 reload, level 3 reload hits the floor
      push(1);
      chk("lvl2_reload", int'(time_v), TIME_INIT - TIME_STEP);
      push(0); push(1);
      chk("lvl3_floor", int'(time_v), TIME_MIN);

      // Reset mid-PLAY with time partially consumed
      repeat (2) apply(0, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0);

      // Play to MAX_LEVEL and win, then return to IDLE
      push(0);
      repeat (MAX_LEVEL - 1) begin push(0); push(1); end
      push(0); push(1);
      chk("win_state", int'(state), 3);
      push(0);

      // Timeout: let the countdown run out
      push(0);
      repeat (TIME_INIT) begin apply(0, 0, 0, 0, 1); apply(0, 0, 0, 0, 0); end
      if (m_state != 3) apply(0, 0, 0, 1, 0);
      push(0);

      // Abort with press in CHECK, then abort while IDLE
      push(0); push(0);
      apply(0, 1, 1, 1, 0);
      apply(0, 0, 0, 0, 0);
      push(0);
      apply(0, 0, 0, 1, 0);
      apply(0, 0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit r, g, c, e, t;
         r = ($urandom_range(0, 199) == 0);
         g = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 1) == 1);
         t = ($urandom_range(0, 2) == 0);
         e = (m_state == 1 || m_state == 2) && ($urandom_range(0, 39) == 0);
         apply(r, g, c, e, t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_speles_logika_v2
`default_nettype wire
